// File: rtl/gadget_decompose_pkg.sv
// ----------------------------------------------------------------------------
// gadget_decompose_pkg
// Shared TFHE definitions used by the gadget decomposition block and its
// sequential divider.
//   N_DIGITS   : number of gadget digits produced (GPow0..GPow2)
//   gd_state_t : control FSM state encoding
// ----------------------------------------------------------------------------
package gadget_decompose_pkg;

    localparam int N_DIGITS = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_ADJ,
        ST_DONE
    } gd_state_t;

endpackage

// File: rtl/gadget_decompose_divrem.sv
// ----------------------------------------------------------------------------
// gadget_decompose_divrem
// Restoring divider, one quotient bit per cycle, DATA_WIDTH bits total.
// The first bit is resolved on the start edge itself (operands taken straight
// from the inputs), so the result is valid DATA_WIDTH-1 edges after start and
// a caller waiting on o_done spends exactly DATA_WIDTH cycles waiting.
// Operands are treated as unsigned; the divisor must be non-zero and below
// 2^(DATA_WIDTH-1) so the shifted partial remainder never overflows.
//   clk, rst     : clock, asynchronous active-high reset
//   i_start      : load operands and begin (may be pulsed again at any time)
//   i_dividend   : dividend
//   i_divisor    : divisor
//   o_quotient   : quotient, valid while o_done=1
//   o_remainder  : remainder, valid while o_done=1
//   o_done       : result valid (level, cleared by the next i_start)
// ----------------------------------------------------------------------------
module gadget_decompose_divrem #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic [DATA_WIDTH-1:0] o_quotient,
    output logic [DATA_WIDTH-1:0] o_remainder,
    output logic                  o_done
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_div;
    logic [CW-1:0]         r_cnt;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] w_cur_quo;
    logic [DATA_WIDTH-1:0] w_cur_rem;
    logic [DATA_WIDTH-1:0] w_cur_div;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_fit;
    logic [DATA_WIDTH-1:0] w_step_rem;
    logic [DATA_WIDTH-1:0] w_step_quo;

    // On start the step operates on the fresh operands, otherwise on state.
    assign w_cur_quo  = i_start ? i_dividend : r_quo;
    assign w_cur_rem  = i_start ? '0         : r_rem;
    assign w_cur_div  = i_start ? i_divisor  : r_div;

    // Dividend bits shift out of the quotient register MSB-first while
    // quotient bits shift in at the LSB.
    assign w_shift    = {w_cur_rem, w_cur_quo[DATA_WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, w_cur_div};
    assign w_fit      = ~w_diff[DATA_WIDTH];
    assign w_step_rem = w_fit ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
    assign w_step_quo = {w_cur_quo[DATA_WIDTH-2:0], w_fit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_quo  <= w_step_quo;
            r_rem  <= w_step_rem;
            r_div  <= i_divisor;
            r_cnt  <= CW'(DATA_WIDTH - 1);
            r_done <= (DATA_WIDTH == 1);
        end else if (r_cnt != '0) begin
            r_quo  <= w_step_quo;
            r_rem  <= w_step_rem;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == CW'(1))
                r_done <= 1'b1;
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_done      = r_done;

endmodule

// File: rtl/gadget_decompose.sv
// ----------------------------------------------------------------------------
// gadget_decompose
// Balanced gadget decomposition of one coefficient into N_DIGITS digits:
//   value_n = D0 + D1*Bg + D2*Bg^2 + carry_out*Bg^3,  -Bg/2 < Di <= Bg/2
// where value_n is value lifted into [0, Q). Each digit costs one sequential
// divide (DATA_WIDTH cycles) plus one balancing cycle.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : request, sampled only while ready=1
//   Bg, Q, value   : gadget base, modulus, coefficient (signed, |value| < Q)
//   D0, D1, D2     : balanced digits, least significant first
//   carry_out      : residual quotient after the last digit
//   err            : Bg<2 or Q<=0 at capture; digits are then all zero
//   ready, done    : level status (ready in IDLE/DONE, done in DONE)
// ----------------------------------------------------------------------------
module gadget_decompose
    import gadget_decompose_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_DIGITS   = gadget_decompose_pkg::N_DIGITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] Bg,
    input  logic signed [DATA_WIDTH-1:0] Q,
    input  logic signed [DATA_WIDTH-1:0] value,
    output logic signed [DATA_WIDTH-1:0] D0,
    output logic signed [DATA_WIDTH-1:0] D1,
    output logic signed [DATA_WIDTH-1:0] D2,
    output logic        [DATA_WIDTH-1:0] carry_out,
    output logic                         err,
    output logic                         ready,
    output logic                         done
);

    localparam logic [1:0] LAST_IDX = 2'(N_DIGITS - 1);

    gd_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_bg;
    logic [1:0]            r_idx;
    logic [DATA_WIDTH-1:0] r_d [N_DIGITS];
    logic [DATA_WIDTH-1:0] r_carry;
    logic                  r_err;
    logic                  r_done;
    logic                  r_ready;

    logic                  w_err_in;
    logic [DATA_WIDTH-1:0] w_vn;
    logic                  w_div_start;
    logic [DATA_WIDTH-1:0] w_dividend;
    logic [DATA_WIDTH-1:0] w_divisor;
    logic [DATA_WIDTH-1:0] w_quo;
    logic [DATA_WIDTH-1:0] w_rem;
    logic                  w_div_done;
    logic                  w_round_up;
    logic [DATA_WIDTH-1:0] w_digit;
    logic [DATA_WIDTH-1:0] w_qadj;

    assign w_err_in = (Bg < $signed(DATA_WIDTH'(2))) || (Q < $signed(DATA_WIDTH'(1)));

    // value+Q lies in [0, Q) for negative inputs, so the DATA_WIDTH-bit sum
    // is exact even though the wider sum is what the lift means.
    assign w_vn = value[DATA_WIDTH-1] ? DATA_WIDTH'(value + Q) : value;

    // Balancing: a remainder above Bg/2 becomes negative and pushes one
    // into the running quotient. r == Bg/2 stays positive.
    assign w_round_up = {w_rem, 1'b0} > {1'b0, r_bg};
    assign w_digit    = w_round_up ? (w_rem - r_bg) : w_rem;
    assign w_qadj     = w_quo + {{(DATA_WIDTH-1){1'b0}}, w_round_up};

    // The divider is kicked on the edge leaving LOAD or a non-final ADJ, so
    // the DIV state lasts exactly DATA_WIDTH cycles per digit.
    assign w_div_start = ((r_state == ST_LOAD) && !w_err_in) ||
                         ((r_state == ST_ADJ)  && (r_idx != LAST_IDX));
    assign w_dividend  = (r_state == ST_LOAD) ? w_vn : w_qadj;
    assign w_divisor   = (r_state == ST_LOAD) ? DATA_WIDTH'(Bg) : r_bg;

    gadget_decompose_divrem #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_divrem (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_div_start),
        .i_dividend  (w_dividend),
        .i_divisor   (w_divisor),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_done      (w_div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bg    <= '0;
            r_idx   <= '0;
            for (int i = 0; i < N_DIGITS; i++)
                r_d[i] <= '0;
            r_carry <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // The error path enters DONE without done set; it rises
                    // here one cycle later.
                    if (r_state == ST_DONE)
                        r_done <= 1'b1;
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_done  <= 1'b0;
                        r_ready <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_bg  <= DATA_WIDTH'(Bg);
                    r_idx <= '0;
                    r_err <= w_err_in;
                    if (w_err_in) begin
                        for (int i = 0; i < N_DIGITS; i++)
                            r_d[i] <= '0;
                        r_carry <= '0;
                        r_ready <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (w_div_done)
                        r_state <= ST_ADJ;
                end
                ST_ADJ: begin
                    r_d[r_idx] <= w_digit;
                    if (r_idx == LAST_IDX) begin
                        r_carry <= w_qadj;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_DIV;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign D0        = r_d[0];
    assign D1        = r_d[1];
    assign D2        = r_d[2];
    assign carry_out = r_carry;
    assign err       = r_err;
    assign ready     = r_ready;
    assign done      = r_done;

endmodule

// File: tb/tb_gadget_decompose.sv
// ----------------------------------------------------------------------------
// tb_gadget_decompose
// Directed vector table for gadget_decompose at DATA_WIDTH=32, plus
// hand-written sequences for mid-operation reset and start while busy.
// ----------------------------------------------------------------------------
module tb_gadget_decompose;

    localparam int W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic signed [W-1:0] Bg, Q, value;
    logic signed [W-1:0] D0, D1, D2;
    logic        [W-1:0] carry_out;
    logic                err, ready, done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    gadget_decompose #(.DATA_WIDTH(W), .N_DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .Bg        (Bg),
        .Q         (Q),
        .value     (value),
        .D0        (D0),
        .D1        (D1),
        .D2        (D2),
        .carry_out (carry_out),
        .err       (err),
        .ready     (ready),
        .done      (done)
    );

    typedef struct {
        logic signed [W-1:0] bg;
        logic signed [W-1:0] q;
        logic signed [W-1:0] val;
        logic signed [W-1:0] d0;
        logic signed [W-1:0] d1;
        logic signed [W-1:0] d2;
        logic signed [W-1:0] carry;
        logic                err;
        int                  lat;
    } vec_t;

    vec_t tv [9];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Launch one operation; optionally re-pulse start (with poisoned inputs)
    // at edge rp while busy. Edge 0 is the edge that samples start.
    task automatic run_vec(input vec_t v, input int id, input int rp);
        int lat;
        lat = -1;
        @(negedge clk);
        Bg = v.bg; Q = v.q; value = v.val; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            if (n == rp) begin
                start = 1'b1; Bg = 32'sd1; value = 32'sd77;
            end
            @(posedge clk); #1;
            if (n == rp) start = 1'b0;
            if (n == 1 && !v.err) chk($sformatf("v%0d.ready_busy", id), ready, 0);
            if (done) begin lat = n; break; end
        end
        chk($sformatf("v%0d.latency", id), lat, v.lat);
        chk($sformatf("v%0d.D0", id), D0, v.d0);
        chk($sformatf("v%0d.D1", id), D1, v.d1);
        chk($sformatf("v%0d.D2", id), D2, v.d2);
        chk($sformatf("v%0d.carry", id), $signed(carry_out), v.carry);
        chk($sformatf("v%0d.err", id), err, v.err);
        chk($sformatf("v%0d.ready", id), ready, 1);
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("v%0d.D0_hold", id), D0, v.d0);
        chk($sformatf("v%0d.done_hold", id), done, 1);
    endtask

    initial begin
        //           bg        q            val         d0     d1    d2      carry  err lat
        tv[0] = '{32'sd64,  32'sd1048576, 32'sd1000,   -32'sd24, 32'sd16, 32'sd0,  32'sd0,  1'b0, 100};
        tv[1] = '{32'sd16,  32'sd4096,    -32'sd1,     -32'sd1,  32'sd0,  32'sd0,  32'sd1,  1'b0, 100};
        tv[2] = '{32'sd16,  32'sd4096,    32'sd8,      32'sd8,   32'sd0,  32'sd0,  32'sd0,  1'b0, 100};
        tv[3] = '{32'sd1,   32'sd4096,    32'sd123,    32'sd0,   32'sd0,  32'sd0,  32'sd0,  1'b1, 2};
        tv[4] = '{32'sd16,  32'sd4096,    32'sd9,      -32'sd7,  32'sd1,  32'sd0,  32'sd0,  1'b0, 100};
        tv[5] = '{32'sd10,  32'sd100000,  32'sd12345,  32'sd5,   32'sd4,  32'sd3,  32'sd12, 1'b0, 100};
        tv[6] = '{32'sd16,  32'sd0,       32'sd5,      32'sd0,   32'sd0,  32'sd0,  32'sd0,  1'b1, 2};
        tv[7] = '{32'sd256, 32'sd1048576, -32'sd1000,  32'sd24,  -32'sd4, 32'sd16, 32'sd0,  1'b0, 100};
        tv[8] = '{32'sd2,   32'sd100,     32'sd7,      32'sd1,   32'sd1,  32'sd1,  32'sd0,  1'b0, 100};

        rst = 1'b1; start = 1'b0; Bg = '0; Q = '0; value = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rst.D0", D0, 0);
        chk("rst.carry", carry_out, 0);
        chk("rst.err", err, 0);
        chk("rst.done", done, 0);
        chk("rst.ready", ready, 1);

        for (int i = 0; i < 9; i++) run_vec(tv[i], i, 0);

        // Reset in the middle of an operation after a nonzero result.
        run_vec(tv[5], 50, 0);
        @(negedge clk);
        Bg = tv[0].bg; Q = tv[0].q; value = tv[0].val; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #2; rst = 1'b1; #1;
        chk("midrst.D0", D0, 0);
        chk("midrst.D1", D1, 0);
        chk("midrst.D2", D2, 0);
        chk("midrst.carry", carry_out, 0);
        chk("midrst.err", err, 0);
        chk("midrst.done", done, 0);
        chk("midrst.ready", ready, 1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst.ready", ready, 1);
        chk("postrst.done", done, 0);
        run_vec(tv[0], 51, 0);

        // Start re-pulsed at edge 10 with different inputs: ignored.
        run_vec(tv[7], 52, 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gadget_decompose.md
GADGET_DECOMPOSE -- requirements
Module: GadgetDecompose

Interface
REQ-001 The module SHALL expose parameter DATA_WIDTH, default 32, meaning the width of all data ports.
REQ-002 The module SHALL expose parameter N_DIGITS, fixed at 3, meaning the number of gadget digits, matching GPow0..GPow2.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock.
REQ-004 The module SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit, a request pulse sampled only while ready=1.
REQ-006 The module SHALL have ports Bg and Q, input, DATA_WIDTH bits each, signed, meaning the gadget base and the modulus.
REQ-007 The module SHALL have port value, input, DATA_WIDTH bits, signed, meaning the coefficient to decompose, valid range (-Q, Q).
REQ-008 The module SHALL have ports D0, D1 and D2, output, DATA_WIDTH bits each, signed, meaning the balanced digits, least significant first.
REQ-009 The module SHALL have port carry_out, output, DATA_WIDTH bits, meaning the residual quotient after the last digit.
REQ-010 The module SHALL have port err, output, 1 bit, meaning Bg<2 or Q<=0 at capture.
REQ-011 The module SHALL have ports ready and done, output, 1 bit each, both level signals.

Function
REQ-012 The module SHALL compute digits satisfying value_n = D0 + D1*Bg + D2*Bg^2 + carry_out*Bg^3, where value_n = value if value>=0, else value+Q.
REQ-013 Each digit SHALL satisfy -Bg/2 < Di <= Bg/2: remainder r>=0, and if 2r>Bg then Di=r-Bg and the running quotient is incremented by 1, else Di=r.
REQ-014 The FSM states SHALL be IDLE, LOAD, DIV, ADJ and DONE.
REQ-015 Transition IDLE/DONE->LOAD SHALL occur on start; LOAD captures Bg, Q and value_n, clears done, sets digit index 0 and checks err.
REQ-016 LOAD SHALL go to DONE if err, else to DIV; DIV SHALL run a restoring divide of the running quotient by Bg, one bit per cycle, for exactly DATA_WIDTH cycles.
REQ-017 ADJ SHALL take 1 cycle to apply the REQ-013 rule, write Di and increment the index; after index 2 it SHALL latch carry_out and go to DONE, otherwise return to DIV.
REQ-018 The latency SHALL be exactly 1+3*(DATA_WIDTH+1) cycles from the start-sampling edge to done=1, i.e. 100 cycles at DATA_WIDTH=32; with err set, done SHALL rise 1 cycle after LOAD.
REQ-019 ready SHALL be 1 in IDLE and DONE, and 0 otherwise; start while ready=0 SHALL be ignored with no effect.
REQ-020 done SHALL hold 1 in DONE until the next accepted start, and outputs SHALL remain stable throughout DONE.
REQ-021 On err, D0..D2 and carry_out SHALL be 0.
REQ-022 All arithmetic SHALL use DATA_WIDTH+1 bits internally, and no intermediate SHALL overflow for |value|<Q<2^(DATA_WIDTH-1).
REQ-023 Inputs SHALL be sampled only in LOAD, so input changes afterwards have no effect.

Reset
REQ-024 rst=1 SHALL force IDLE immediately, including mid-operation, with D0..D2=0, carry_out=0, err=0, done=0 and ready=1 after release.
REQ-025 The first accepted start after reset release SHALL behave identically to any later start.

Structure
REQ-026 The FSM state encoding and the N_DIGITS constant SHALL reside in the shared TFHE package.
REQ-027 The restoring divider SHALL be a single sub-module, DivRemSeq (dividend, divisor, start -> quotient, remainder, done), reusable by ModMulFast-class blocks.

Verification
REQ-028 The bench SHALL cover: Bg=64, Q=1048576, value=1000 -> D0=-24, D1=16, D2=0, carry_out=0, done at cycle 100.
REQ-029 The bench SHALL cover: Bg=16, Q=4096, value=-1 -> value_n=4095, D0=-1, D1=0, D2=0, carry_out=1.
REQ-030 The bench SHALL cover the boundary: Bg=16, Q=4096, value=8 -> D0=8 (r=Bg/2 stays positive), D1=0, D2=0.
REQ-031 The bench SHALL cover: Bg=1, any value -> err=1, all digits 0, done 2 cycles after start.
REQ-032 The bench SHALL cover: rst pulsed at cycle 40 of an operation -> outputs 0 and ready=1 immediately, then a new start completes correctly.
REQ-033 The bench SHALL cover: start re-pulsed at cycle 10 while busy -> ignored, and the original result is delivered at cycle 100.
